uart_rx_engine: RTL and testbench
=================================

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter DATA_W_MAX, 8, widest supported data field in bits.
REQ-002 Parameter OVERSAMPLE, 16, rx_tick pulses per bit period.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port resetn  input  1  synchronous, active-low reset.
REQ-005 Port rx_tick  input  1  one-clk pulse at OVERSAMPLE x baud, from the baud tick generator.
REQ-006 Port rxd  input  1  asynchronous serial line; idle high.
REQ-007 Port cfg_data_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8.
REQ-008 Port cfg_parity_en  input  1  1 = parity bit follows the data.
REQ-009 Port cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 Port cfg_stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-011 Port rx_data  output  8  last received data, LSB-aligned, upper unused bits 0.
REQ-012 Port rx_valid  output  1  one-clk pulse when a frame completes.
REQ-013 Port parity_err  output  1  parity status of the last frame; valid with rx_valid.
REQ-014 Port frame_err  output  1  a stop bit sampled low; valid with rx_valid.
REQ-015 Port break_det  output  1  data, parity and stop all sampled low; valid with rx_valid.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 rxd shall pass through a 2-flop synchronizer (rxd_s) before any use; both flops reset to 1.
REQ-018 The FSM shall have states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 The tick counter (4 bits) and the bit counter (3 bits) shall advance only on clk edges where rx_tick=1.
REQ-020 IDLE: when rxd_s=0, go to START and clear the tick counter.
REQ-021 START: on the 8th rx_tick (mid-bit), sample rxd_s. If 1, treat it as a glitch and return to IDLE with no outputs. If 0, latch all cfg_* inputs, clear the counters, and go to DATA.
REQ-022 cfg_* changes after the latch in REQ-021 shall not affect the current frame.
REQ-023 DATA: sample rxd_s every 16th rx_tick, shifting data in LSB first. After the latched number of bits, go to PARITY if parity is enabled, otherwise go to STOP.
REQ-024 PARITY: sample after 16 ticks. parity_err = XOR(data bits, parity bit) XOR cfg_parity_odd_latched. parity_err shall be 0 when parity is disabled.
REQ-025 STOP: sample after 16 ticks. With cfg_stop2, sample a second stop bit 16 ticks later. frame_err = 1 if any stop sample is 0.
REQ-026 On the clk edge of the final stop sample, update rx_data and the error flags. rx_valid shall be 1 on the following clk cycle only.
REQ-027 After the final stop sample: if that sample is 1, go to IDLE. If it is 0, go to WAIT_HIGH, and leave WAIT_HIGH for IDLE only when rxd_s=1.
REQ-028 break_det = 1 iff frame_err=1 and every data bit and the parity bit (if enabled) are 0.
REQ-029 rx_data, parity_err, frame_err and break_det shall hold their values until the next rx_valid.
REQ-030 The 4-bit tick counter wraps 15->0. Mid-bit alignment comes from the 8-tick START offset.
REQ-031 rx_tick=0 for any number of cycles shall freeze all counters and the FSM state; this is not an error.

Reset
REQ-032 resetn=0 at a clk edge shall force: FSM=IDLE, counters=0, rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, break_det=0, busy=0, synchronizer flops=1.
REQ-033 Reset mid-frame shall discard the partial frame without pulsing rx_valid. After release, the next falling edge on rxd starts a fresh frame.

Verification
REQ-034 8N1 frame 0xA5 with a correct stop bit -> exactly one rx_valid pulse, rx_data=0xA5, all error flags 0, busy returns to 0.
REQ-035 8E1 frame 0x37 with parity bit 1, then the same frame with parity bit 0 -> first frame parity_err=0, second frame parity_err=1, rx_data=0x37 both times.
REQ-036 5O2 frame 0x15 (cfg_data_bits=00) with the second stop bit low -> rx_data=0x15, frame_err=1, FSM in WAIT_HIGH until rxd returns high.
REQ-037 rxd held low for 4 ticks, then high -> no rx_valid, FSM back in IDLE, busy=0.
REQ-038 rxd held low for 12 bit periods in 8N1 -> rx_data=0x00, frame_err=1, break_det=1, exactly one rx_valid, no second frame until rxd goes high.
REQ-039 resetn=0 during DATA bit 3, then a valid frame 0x5A -> no rx_valid for the aborted frame, then rx_data=0x5A with all error flags 0.

Source files
------------

// File: rtl/uart_rx_engine_if.sv
// rtl/uart_rx_engine_if.sv - received-frame result bundle from the UART receive engine
interface uart_rx_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              break_det;
  logic              busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, busy
  );

  modport slave (
    input rx_data, rx_valid, parity_err, frame_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - oversampled UART receiver with parity, stop and break checks
module uart_rx_engine #(
  parameter int DATA_W_MAX = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_tick,
  input  logic                 rxd,
  input  logic [1:0]           cfg_data_bits,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  uart_rx_engine_if.master     rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                state;
  logic                  rxd_m, rxd_s;
  logic [TW-1:0]         tick_cnt;
  logic [2:0]            bit_cnt;
  logic [1:0]            bits_l;
  logic                  par_en_l, par_odd_l, stop2_l;
  logic [DATA_W_MAX-1:0] shift_r;
  logic                  par_acc, par_bit, par_err_acc, stop_low;
  logic [DATA_W_MAX-1:0] rx_data_r;
  logic                  rx_valid_r, parity_err_r, frame_err_r, break_r;
  logic                  stop_fail;

  // Frame error folds in the first stop bit (two-stop mode) and the one sampled now.
  assign stop_fail = stop_low | ~rxd_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      rxd_m        <= 1'b1;
      rxd_s        <= 1'b1;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      bits_l       <= '0;
      par_en_l     <= 1'b0;
      par_odd_l    <= 1'b0;
      stop2_l      <= 1'b0;
      shift_r      <= '0;
      par_acc      <= 1'b0;
      par_bit      <= 1'b0;
      par_err_acc  <= 1'b0;
      stop_low     <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      break_r      <= 1'b0;
    end else begin
      rxd_m      <= rxd;
      rxd_s      <= rxd_m;
      rx_valid_r <= 1'b0;
      if (rx_tick) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              state    <= S_START;
              tick_cnt <= '0;
            end
          end
          S_START: begin
            if (tick_cnt == TICK_MID) begin
              if (rxd_s) begin
                state <= S_IDLE;
              end else begin
                bits_l      <= cfg_data_bits;
                par_en_l    <= cfg_parity_en;
                par_odd_l   <= cfg_parity_odd;
                stop2_l     <= cfg_stop2;
                tick_cnt    <= '0;
                bit_cnt     <= '0;
                shift_r     <= '0;
                par_acc     <= 1'b0;
                par_bit     <= 1'b0;
                par_err_acc <= 1'b0;
                stop_low    <= 1'b0;
                state       <= S_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          S_DATA: begin
            tick_cnt <= tick_cnt + TICK_ONE;
            if (tick_cnt == TICK_LAST) begin
              shift_r[bit_cnt] <= rxd_s;
              par_acc          <= par_acc ^ rxd_s;
              bit_cnt          <= bit_cnt + 3'd1;
              // Last index is length-1, i.e. 4..7 for 5..8 data bits.
              if (bit_cnt == {1'b1, bits_l}) begin
                bit_cnt <= '0;
                state   <= par_en_l ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            tick_cnt <= tick_cnt + TICK_ONE;
            if (tick_cnt == TICK_LAST) begin
              par_bit     <= rxd_s;
              par_err_acc <= par_acc ^ rxd_s ^ par_odd_l;
              state       <= S_STOP;
            end
          end
          S_STOP: begin
            tick_cnt <= tick_cnt + TICK_ONE;
            if (tick_cnt == TICK_LAST) begin
              if (stop2_l && bit_cnt == 3'd0) begin
                stop_low <= ~rxd_s;
                bit_cnt  <= 3'd1;
              end else begin
                rx_data_r    <= shift_r;
                parity_err_r <= par_err_acc;
                frame_err_r  <= stop_fail;
                break_r      <= stop_fail && (shift_r == '0) && !(par_en_l && par_bit);
                rx_valid_r   <= 1'b1;
                bit_cnt      <= '0;
                state        <= rxd_s ? S_IDLE : S_WAIT_HIGH;
              end
            end
          end
          S_WAIT_HIGH: begin
            if (rxd_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx.rx_data    = rx_data_r;
  assign rx.rx_valid   = rx_valid_r;
  assign rx.parity_err = parity_err_r;
  assign rx.frame_err  = frame_err_r;
  assign rx.break_det  = break_r;
  assign rx.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed self-checking bench for uart_rx_engine
module tb_uart_rx_engine;
  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] cfg_data_bits = 2'b11;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic [1:0] tick_div = 2'd0;
  int         valid_cnt = 0;
  int         total = 0;
  int         bad = 0;

  uart_rx_engine_if rx_if ();

  uart_rx_engine dut (
    .clk            (clk),
    .resetn         (resetn),
    .rx_tick        (rx_tick),
    .rxd            (rxd),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .rx             (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    rx_tick  <= (tick_div == 2'd3);
  end

  always @(negedge clk) begin
    if (rx_if.rx_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    @(negedge clk);
    rxd = b;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                            input bit pbit, input bit s1, input bit s2en, input bit s2,
                            input bit scramble);
    hold(1'b0, BIT_CLKS);
    if (scramble) begin
      cfg_data_bits  = ~cfg_data_bits;
      cfg_parity_en  = ~cfg_parity_en;
      cfg_parity_odd = ~cfg_parity_odd;
      cfg_stop2      = ~cfg_stop2;
    end
    for (int i = 0; i < nbits; i++) hold(d[i], BIT_CLKS);
    if (pen) hold(pbit, BIT_CLKS);
    hold(s1, BIT_CLKS);
    if (s2en) hold(s2, BIT_CLKS);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    settle(6);
    check("reset_rx_data", rx_if.rx_data, 8'h00);
    check("reset_rx_valid", rx_if.rx_valid, 1'b0);
    check("reset_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 3'b000);
    check("reset_busy", rx_if.busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    hold(1'b1, 32);

    // 8N1 0xA5, config toggled mid-frame must be ignored
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 32);
    settle(1);
    check("a5_valid_cnt", valid_cnt, 1);
    check("a5_data", rx_if.rx_data, 8'hA5);
    check("a5_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 3'b000);
    check("a5_busy", rx_if.busy, 1'b0);

    // 8E1 0x37: five ones, so even parity bit is 1
    cfg_data_bits = 2'b11; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    send_frame(8'h37, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 32);
    settle(1);
    check("e1_good_cnt", valid_cnt, 2);
    check("e1_good_data", rx_if.rx_data, 8'h37);
    check("e1_good_perr", rx_if.parity_err, 1'b0);
    send_frame(8'h37, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 32);
    settle(1);
    check("e1_bad_cnt", valid_cnt, 3);
    check("e1_bad_data", rx_if.rx_data, 8'h37);
    check("e1_bad_perr", rx_if.parity_err, 1'b1);
    check("e1_bad_ferr", rx_if.frame_err, 1'b0);

    // 5O2 0x15: three ones, odd parity bit 0; second stop bit low
    cfg_data_bits = 2'b00; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1;
    send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b0, BIT_CLKS);
    settle(1);
    check("o2_cnt", valid_cnt, 4);
    check("o2_data", rx_if.rx_data, 8'h15);
    check("o2_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 3'b010);
    check("o2_wait_high_busy", rx_if.busy, 1'b1);
    hold(1'b1, 32);
    settle(1);
    check("o2_released_busy", rx_if.busy, 1'b0);
    check("o2_no_extra_valid", valid_cnt, 4);

    // Short glitch: low for 4 ticks only
    cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    hold(1'b0, 16);
    hold(1'b1, 128);
    settle(1);
    check("glitch_cnt", valid_cnt, 4);
    check("glitch_busy", rx_if.busy, 1'b0);

    // Break: line low for 12 bit periods in 8N1
    hold(1'b0, 12 * BIT_CLKS);
    settle(1);
    check("brk_cnt", valid_cnt, 5);
    check("brk_data", rx_if.rx_data, 8'h00);
    check("brk_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 3'b011);
    check("brk_busy", rx_if.busy, 1'b1);
    hold(1'b1, BIT_CLKS);
    settle(1);
    check("brk_release_busy", rx_if.busy, 1'b0);
    check("brk_single_valid", valid_cnt, 5);

    // Reset during data bit 3 of 0x5A, then a clean 0x5A
    base = valid_cnt;
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, 32);
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    hold(1'b1, 128);
    settle(1);
    check("rst_abort_cnt", valid_cnt, base);
    check("rst_abort_data", rx_if.rx_data, 8'h00);
    check("rst_abort_busy", rx_if.busy, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 32);
    settle(1);
    check("post_rst_cnt", valid_cnt, base + 1);
    check("post_rst_data", rx_if.rx_data, 8'h5A);
    check("post_rst_flags", {rx_if.parity_err, rx_if.frame_err, rx_if.break_det}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
